bus_io_uart: RTL and testbench

Memory-mapped I/O bridge between the CPU data bus and the system RAM. It contains a UART with TX/RX FIFOs. It decodes every CPU bus cycle: accesses in the I/O window go to internal registers, and all other accesses go to RAM. It also drives the read-data mux back to the CPU. Reads return data combinationally in the same cycle, and every cycle with write-enable high is one byte write.

---
 rtl/io_pkg.sv | 38 +++
 rtl/io_fifo.sv | 61 ++++++
 rtl/bus_io_uart.sv | 254 +++++++++++++++++++++++++
 tb/tb_bus_io_uart.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and state types for the CPU I/O bridge and its UART.
package io_pkg;

    localparam logic [3:0] REG_TXDATA = 4'd0;
    localparam logic [3:0] REG_RXDATA = 4'd1;
    localparam logic [3:0] REG_STATUS = 4'd2;
    localparam logic [3:0] REG_DIV_LO = 4'd3;
    localparam logic [3:0] REG_DIV_HI = 4'd4;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_TX_IDLE   = 1;
    localparam int ST_RX_AVAIL  = 2;
    localparam int ST_RX_OVF    = 3;
    localparam int ST_TX_OVF    = 4;
    localparam int ST_FRAME_ERR = 5;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Byte FIFO with combinational head; full/empty judged on pre-cycle state.
module io_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/bus_io_uart.sv
// CPU bus decoder: 16-byte I/O window holding a UART, everything else goes to RAM.
module bus_io_uart
    import io_pkg::*;
#(
    parameter logic [15:0] IO_BASE     = 16'hFFF0,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd217
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_DATA,
    input  logic        I_WREN,
    output logic [7:0]  O_DATA,
    input  logic [7:0]  RAM_Q,
    output logic        RAM_WREN,
    output logic        UART_TX,
    input  logic        UART_RX
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] ONE16 = 16'd1;
    localparam logic [15:0] TWO16 = 16'd2;

    logic        io_hit, io_wr;
    logic [3:0]  reg_off;
    logic        wr_tx, wr_rx, wr_status, wr_div_lo, wr_div_hi;
    logic [15:0] div_q, div_d, div_eff;
    logic        rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, frame_err_q, frame_err_d;
    logic [7:0]  status, reg_rdata;

    logic          tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_push, rx_full, rx_empty, frame_set;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;

    tx_state_e   tx_state_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_shift_q;
    logic [2:0]  tx_bit_q;
    logic        tx_out_q;

    rx_state_e   rx_state_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [7:0]  rx_shift_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q;

    always_comb begin
        io_hit    = (I_ADDR[15:4] == IO_BASE[15:4]);
        reg_off   = I_ADDR[3:0];
        io_wr     = I_WREN & io_hit;
        wr_tx     = io_wr & (reg_off == REG_TXDATA);
        wr_rx     = io_wr & (reg_off == REG_RXDATA);
        wr_status = io_wr & (reg_off == REG_STATUS);
        wr_div_lo = io_wr & (reg_off == REG_DIV_LO);
        wr_div_hi = io_wr & (reg_off == REG_DIV_HI);
        div_eff   = clamp_div(div_q);
    end

    // Sticky flags: a set event in the same cycle as a write-1-clear wins.
    always_comb begin
        div_d = div_q;
        if (wr_div_lo) div_d[7:0]  = I_DATA;
        if (wr_div_hi) div_d[15:8] = I_DATA;
        rx_ovf_d    = (rx_push & rx_full) | (rx_ovf_q & ~(wr_status & I_DATA[ST_RX_OVF]));
        tx_ovf_d    = (wr_tx & tx_full)   | (tx_ovf_q & ~(wr_status & I_DATA[ST_TX_OVF]));
        frame_err_d = frame_set | (frame_err_q & ~(wr_status & I_DATA[ST_FRAME_ERR]));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            div_q       <= DEFAULT_DIV;
            rx_ovf_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            rx_ovf_q    <= rx_ovf_d;
            tx_ovf_q    <= tx_ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(CLOCK), .rst(RESET), .push(wr_tx), .pop(tx_pop), .wdata(I_DATA),
        .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    io_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(CLOCK), .rst(RESET), .push(rx_push), .pop(wr_rx), .wdata(rx_shift_q),
        .rdata(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Pop on IDLE or at the end of STOP so back-to-back frames have no gap.
    always_comb begin
        tx_pop = ~tx_empty & ((tx_state_q == TX_IDLE) ||
                              ((tx_state_q == TX_STOP) && (tx_cnt_q == '0)));
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= MIN_DIV;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_out_q <= 1'b1;
                    if (tx_pop) begin
                        tx_state_q <= TX_START;
                        tx_div_q   <= div_eff;
                        tx_cnt_q   <= div_eff - ONE16;
                        tx_shift_q <= tx_head;
                        tx_out_q   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == '0) begin
                        tx_state_q <= TX_DATA;
                        tx_cnt_q   <= tx_div_q - ONE16;
                        tx_bit_q   <= '0;
                        tx_out_q   <= tx_shift_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q - ONE16;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == '0) begin
                        tx_cnt_q <= tx_div_q - ONE16;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= TX_STOP;
                            tx_out_q   <= 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_out_q   <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - ONE16;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == '0) begin
                        if (tx_pop) begin
                            tx_state_q <= TX_START;
                            tx_div_q   <= div_eff;
                            tx_cnt_q   <= div_eff - ONE16;
                            tx_shift_q <= tx_head;
                            tx_out_q   <= 1'b0;
                        end else begin
                            tx_state_q <= TX_IDLE;
                            tx_out_q   <= 1'b1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - ONE16;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                    tx_out_q   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= UART_RX;
            rx_s2_q <= rx_s1_q;
        end
    end

    always_comb begin
        rx_push   = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_s2_q;
        frame_set = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && !rx_s2_q;
    end

    // The start-bit wait is two short of div/2: edge detection already cost that much.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= MIN_DIV;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_s2_q) begin
                        rx_state_q <= RX_START;
                        rx_div_q   <= div_eff;
                        rx_cnt_q   <= (div_eff >> 1) - TWO16;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == '0) begin
                        if (rx_s2_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= rx_div_q - ONE16;
                            rx_bit_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - ONE16;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        rx_cnt_q   <= rx_div_q - ONE16;
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - ONE16;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == '0) rx_state_q <= rx_s2_q ? RX_IDLE : RX_BREAK;
                    else                rx_cnt_q   <= rx_cnt_q - ONE16;
                end
                RX_BREAK: begin
                    if (rx_s2_q) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    always_comb begin
        status = {2'b00, frame_err_q, tx_ovf_q, rx_ovf_q, (rx_count != '0),
                  (tx_count == '0) && (tx_state_q == TX_IDLE), tx_full};
        case (reg_off)
            REG_RXDATA: reg_rdata = rx_empty ? 8'h00 : rx_head;
            REG_STATUS: reg_rdata = status;
            REG_DIV_LO: reg_rdata = div_q[7:0];
            REG_DIV_HI: reg_rdata = div_q[15:8];
            default:    reg_rdata = 8'h00;
        endcase
    end

    assign O_DATA   = io_hit ? reg_rdata : RAM_Q;
    assign RAM_WREN = I_WREN & ~io_hit;
    assign UART_TX  = tx_out_q;

endmodule

// File: tb/tb_bus_io_uart.sv
// Self-checking bench for bus_io_uart: decode vectors, TX/RX scoreboards, FIFO and reset corners.
module tb_bus_io_uart;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] I_ADDR = 16'h0000;
    logic [7:0]  I_DATA = 8'h00;
    logic        I_WREN = 1'b0;
    logic [7:0]  O_DATA;
    logic [7:0]  RAM_Q = 8'h00;
    logic        RAM_WREN;
    logic        UART_TX;
    logic        UART_RX = 1'b1;

    bus_io_uart dut (
        .CLOCK(CLOCK), .RESET(RESET), .I_ADDR(I_ADDR), .I_DATA(I_DATA),
        .I_WREN(I_WREN), .O_DATA(O_DATA), .RAM_Q(RAM_Q), .RAM_WREN(RAM_WREN),
        .UART_TX(UART_TX), .UART_RX(UART_RX)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_div  = 217;
    bit mon_en   = 1'b1;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wren;
        logic [7:0]  ram_q;
        logic [7:0]  exp_data;
        logic        exp_ram_wren;
    } vec_t;
    vec_t vecs[12];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(posedge CLOCK); #1;
        I_ADDR = addr; I_DATA = data; I_WREN = 1'b1;
        @(posedge CLOCK); #1;
        I_WREN = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [15:0] addr, input logic [7:0] exp);
        I_ADDR = addr; I_WREN = 1'b0;
        #1;
        check8(name, O_DATA, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int d);
        @(posedge CLOCK); #1;
        UART_RX = 1'b0;
        repeat (d) @(posedge CLOCK);
        for (int i = 0; i < 8; i++) begin
            #1 UART_RX = b[i];
            repeat (d) @(posedge CLOCK);
        end
        #1 UART_RX = stop_val;
        repeat (d) @(posedge CLOCK);
        #1 UART_RX = 1'b1;
    endtask

    // Decodes every frame seen on UART_TX and checks it against the queued bytes.
    initial begin : tx_mon
        forever begin
            @(negedge CLOCK);
            if (mon_en && !RESET && UART_TX === 1'b0) begin : frame
                logic [7:0] b;
                logic       s;
                int         d;
                d = cur_div;
                repeat (d / 2) @(negedge CLOCK);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge CLOCK);
                    b[i] = UART_TX;
                end
                repeat (d) @(negedge CLOCK);
                s = UART_TX;
                check1("tx_stop_bit", s, 1'b1);
                if (tx_exp.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected_frame: got 0x%02h expected none", b);
                end else begin
                    check8("tx_frame_byte", b, tx_exp.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] pat;
        logic [7:0] exp_bit;
        logic [7:0] st;
        bit         seen;
        bit         went_low;

        vecs[0]  = '{16'hFFF2, 8'h00, 1'b0, 8'h00, 8'h02, 1'b0};
        vecs[1]  = '{16'hFFF3, 8'h00, 1'b0, 8'h00, 8'hD9, 1'b0};
        vecs[2]  = '{16'hFFF4, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{16'hFFF0, 8'h00, 1'b0, 8'h44, 8'h00, 1'b0};
        vecs[4]  = '{16'hFFF1, 8'h00, 1'b0, 8'h44, 8'h00, 1'b0};
        vecs[5]  = '{16'h1234, 8'h77, 1'b1, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{16'h1234, 8'h00, 1'b0, 8'h9C, 8'h9C, 1'b0};
        vecs[7]  = '{16'hFFF7, 8'h00, 1'b0, 8'h5A, 8'h00, 1'b0};
        vecs[8]  = '{16'hFFF7, 8'hAB, 1'b1, 8'h5A, 8'h00, 1'b0};
        vecs[9]  = '{16'hFFEF, 8'h00, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vecs[10] = '{16'h0000, 8'h00, 1'b0, 8'hA5, 8'hA5, 1'b0};
        vecs[11] = '{16'hFFFF, 8'h00, 1'b0, 8'h11, 8'h00, 1'b0};

        repeat (3) @(posedge CLOCK);
        #1 RESET = 1'b0;
        check1("reset_uart_tx", UART_TX, 1'b1);

        for (int i = 0; i < 12; i++) begin
            @(posedge CLOCK); #1;
            I_ADDR = vecs[i].addr; I_DATA = vecs[i].wdata;
            I_WREN = vecs[i].wren; RAM_Q  = vecs[i].ram_q;
            @(negedge CLOCK);
            check8($sformatf("vec%0d_o_data", i), O_DATA, vecs[i].exp_data);
            check1($sformatf("vec%0d_ram_wren", i), RAM_WREN, vecs[i].exp_ram_wren);
        end
        @(posedge CLOCK); #1 I_WREN = 1'b0;
        read_check("div_hi_after_ignored_write", 16'hFFF4, 8'h00);

        bus_write(16'hFFF3, 8'h04);
        bus_write(16'hFFF4, 8'h00);
        cur_div = 4;
        read_check("div_lo_readback", 16'hFFF3, 8'h04);

        // Single frame: 0x55 written in cycle W, waveform checked cycle by cycle.
        pat = 8'h55;
        tx_exp.push_back(pat);
        @(posedge CLOCK); #1;
        I_ADDR = 16'hFFF0; I_DATA = pat; I_WREN = 1'b1;
        #1 check1("io_write_no_ram_wren", RAM_WREN, 1'b0);
        @(posedge CLOCK); #1;
        I_WREN = 1'b0;
        for (int n = 1; n <= 41; n++) begin
            if (n == 1)       exp_bit = 8'h01;
            else if (n <= 5)  exp_bit = 8'h00;
            else if (n <= 37) exp_bit = {7'd0, pat[(n - 6) / 4]};
            else              exp_bit = 8'h01;
            check1($sformatf("tx_wave_W+%0d", n), UART_TX, exp_bit[0]);
            @(posedge CLOCK); #1;
        end
        read_check("status_idle_W+42", 16'hFFF2, 8'h02);

        // Ten back-to-back TX writes: nine accepted, the tenth overflows.
        for (int k = 1; k <= 10; k++) begin
            @(posedge CLOCK); #1;
            I_ADDR = 16'hFFF0; I_DATA = 8'(k); I_WREN = 1'b1;
            if (k <= 9) tx_exp.push_back(8'(k));
        end
        @(posedge CLOCK); #1 I_WREN = 1'b0;
        read_check("status_full_ovf", 16'hFFF2, 8'h11);
        bus_write(16'hFFF2, 8'h10);
        read_check("status_ovf_cleared", 16'hFFF2, 8'h01);

        seen = 1'b0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(posedge CLOCK); #1;
            if (tx_exp.size() == 0) seen = 1'b1;
        end
        check1("tx_queue_drained", seen, 1'b1);
        repeat (6) @(posedge CLOCK); #1;
        read_check("status_after_drain", 16'hFFF2, 8'h02);

        // RX: single byte, then two back-to-back bytes in FIFO order.
        rx_exp.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, cur_div);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            I_ADDR = 16'hFFF2; #1;
            if (O_DATA[2]) seen = 1'b1;
            else begin @(posedge CLOCK); #1; end
        end
        check1("rx_avail_set", seen, 1'b1);
        read_check("rx_data_a3", 16'hFFF1, rx_exp.pop_front());
        bus_write(16'hFFF1, 8'h00);
        I_ADDR = 16'hFFF2; #1 check1("rx_avail_clear", O_DATA[2], 1'b0);
        read_check("rx_data_empty", 16'hFFF1, 8'h00);
        bus_write(16'hFFF1, 8'h00);
        read_check("status_pop_empty_ignored", 16'hFFF2, 8'h02);

        rx_exp.push_back(8'h5E);
        rx_exp.push_back(8'h81);
        send_frame(8'h5E, 1'b1, cur_div);
        send_frame(8'h81, 1'b1, cur_div);
        repeat (10) @(posedge CLOCK); #1;
        for (int k = 0; k < 2; k++) begin
            read_check($sformatf("rx_pair_%0d", k), 16'hFFF1, rx_exp.pop_front());
            bus_write(16'hFFF1, 8'h00);
        end
        read_check("status_pair_done", 16'hFFF2, 8'h02);

        // Framing error: stop bit low, byte discarded.
        send_frame(8'hC6, 1'b0, cur_div);
        repeat (10) @(posedge CLOCK); #1;
        read_check("status_frame_err", 16'hFFF2, 8'h22);
        read_check("rx_fifo_unchanged", 16'hFFF1, 8'h00);
        bus_write(16'hFFF2, 8'h20);
        read_check("status_frame_err_clr", 16'hFFF2, 8'h02);

        // RX overflow: nine frames into an eight-deep FIFO.
        for (int k = 0; k < 9; k++) begin
            if (k < 8) rx_exp.push_back(8'h10 + 8'(k));
            send_frame(8'h10 + 8'(k), 1'b1, cur_div);
        end
        repeat (10) @(posedge CLOCK); #1;
        read_check("status_rx_ovf", 16'hFFF2, 8'h0E);
        for (int k = 0; k < 8; k++) begin
            read_check($sformatf("rx_ovf_byte_%0d", k), 16'hFFF1, rx_exp.pop_front());
            bus_write(16'hFFF1, 8'h00);
        end
        read_check("status_rx_ovf_empty", 16'hFFF2, 8'h0A);
        bus_write(16'hFFF2, 8'h08);
        read_check("status_rx_ovf_clr", 16'hFFF2, 8'h02);

        // Reset in the middle of a TX frame.
        mon_en = 1'b0;
        bus_write(16'hFFF3, 8'h06);
        bus_write(16'hFFF0, 8'h5A);
        bus_write(16'hFFF0, 8'h0F);
        repeat (8) @(posedge CLOCK);
        #1 RESET = 1'b1;
        @(posedge CLOCK);
        #1 RESET = 1'b0;
        check1("reset_midframe_tx_high", UART_TX, 1'b1);
        read_check("reset_status", 16'hFFF2, 8'h02);
        read_check("reset_div_lo", 16'hFFF3, 8'hD9);
        went_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLOCK);
            if (UART_TX !== 1'b1) went_low = 1'b1;
        end
        check1("reset_tx_stays_idle", went_low, 1'b0);

        st = 8'(n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
